// File: rtl/weight_fetch_seq.sv
// ---------------------------------------------------------------------------
// weight_fetch_seq
// Weight RAM sequencer for the drowsiness-detector network. Holds the RAM in
// initialise mode for INIT_CYCLES clocks after reset. It then serves row-fetch
// jobs from the layer controller: it steps the RAM address by ROW_STRIDE from
// base_addr and presents each row to the MAC engine over w_valid/w_ready.
//
// Optional feature macro: WFS_STALL_STATS_EN
//   defined   : stall_cnt counts w_valid & !w_ready cycles (saturating,
//               cleared on reset and on job acceptance)
//   undefined : stall_cnt is tied to zero
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               job request, sampled in IDLE only
//   base_addr           first row address of the job
//   row_count           number of rows to fetch
//   abort               synchronous cancel of an in-flight job
//   w_ready             consumer accepts the presented row
//   ram_addr            RAM Address
//   ram_in              RAM In (1 = initialise mode, 0 = read mode)
//   ram_we              RAM WE, always 0
//   w_valid             presented row is valid
//   w_row_idx           0-based index of the presented row within the job
//   busy                job in progress
//   init_done           initialise window complete (sticky)
//   done                one-cycle pulse, job finished
//   err                 one-cycle pulse, job rejected (address range overflow)
//   stall_cnt           backpressure cycle counter
// ---------------------------------------------------------------------------
module weight_fetch_seq #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned ROW_STRIDE  = 10,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned INIT_CYCLES = 100,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  row_count,
    input  logic              abort,
    input  logic              w_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_in,
    output logic              ram_we,
    output logic              w_valid,
    output logic [CNT_W-1:0]  w_row_idx,
    output logic              busy,
    output logic              init_done,
    output logic              done,
    output logic              err,
    output logic [15:0]       stall_cnt
);

    // Range check width is wide enough that base + count*stride never wraps.
    localparam int unsigned CHK_W   = ADDR_W + CNT_W + 4;
    localparam int unsigned INIT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned WAIT_W  = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_PRESENT = 3'd4
    } state_t;

    state_t              state,     state_d;
    logic [INIT_W-1:0]   init_cnt,  init_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt,  wait_cnt_d;
    logic [ADDR_W-1:0]   cur_addr,  cur_addr_d;
    logic [CNT_W-1:0]    last_idx,  last_idx_d;
    logic [ADDR_W-1:0]   ram_addr_d;
    logic                ram_in_d;
    logic                w_valid_d;
    logic [CNT_W-1:0]    w_row_idx_d;
    logic                busy_d;
    logic                init_done_d;
    logic                done_d;
    logic                err_d;

    logic [CHK_W-1:0]    job_end_c;
    logic                too_big_c;
    logic                in_job_c;
    logic                accept_c;

    // Job end address versus the top of the RAM (ending exactly at 2^ADDR_W is legal).
    assign job_end_c = CHK_W'(base_addr) + CHK_W'(row_count) * CHK_W'(ROW_STRIDE);
    assign too_big_c = job_end_c > (CHK_W'(1) << ADDR_W);
    assign in_job_c  = (state == S_ISSUE) || (state == S_WAIT) || (state == S_PRESENT);
    assign accept_c  = (state == S_IDLE) && start && (row_count != '0) && !too_big_c;

    assign ram_we = 1'b0;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        init_cnt_d  = init_cnt;
        wait_cnt_d  = wait_cnt;
        cur_addr_d  = cur_addr;
        last_idx_d  = last_idx;
        ram_addr_d  = ram_addr;
        ram_in_d    = ram_in;
        w_valid_d   = w_valid;
        w_row_idx_d = w_row_idx;
        busy_d      = busy;
        init_done_d = init_done;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (in_job_c && abort) begin
            // Cancel wins over a simultaneous handshake; no done pulse.
            state_d   = S_IDLE;
            w_valid_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state)
                S_INIT: begin
                    if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                        ram_in_d    = 1'b0;
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        init_cnt_d = init_cnt + INIT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        if (row_count == '0) begin
                            done_d = 1'b1;
                        end else if (too_big_c) begin
                            err_d = 1'b1;
                        end else begin
                            cur_addr_d  = base_addr;
                            last_idx_d  = row_count - CNT_W'(1);
                            w_row_idx_d = '0;
                            busy_d      = 1'b1;
                            state_d     = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    ram_addr_d = cur_addr;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    // RAM data appears READ_LAT clocks after the address; w_valid
                    // is registered one clock after that.
                    if (wait_cnt == WAIT_W'(READ_LAT)) begin
                        w_valid_d = 1'b1;
                        state_d   = S_PRESENT;
                    end else begin
                        wait_cnt_d = wait_cnt + WAIT_W'(1);
                    end
                end
                S_PRESENT: begin
                    if (w_ready) begin
                        w_valid_d = 1'b0;
                        if (w_row_idx == last_idx) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            cur_addr_d  = cur_addr + ADDR_W'(ROW_STRIDE);
                            w_row_idx_d = w_row_idx + CNT_W'(1);
                            state_d     = S_ISSUE;
                        end
                    end
                end
                default: begin
                    state_d = S_INIT;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            wait_cnt  <= '0;
            cur_addr  <= '0;
            last_idx  <= '0;
            ram_addr  <= '0;
            ram_in    <= 1'b1;
            w_valid   <= 1'b0;
            w_row_idx <= '0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            init_cnt  <= init_cnt_d;
            wait_cnt  <= wait_cnt_d;
            cur_addr  <= cur_addr_d;
            last_idx  <= last_idx_d;
            ram_addr  <= ram_addr_d;
            ram_in    <= ram_in_d;
            w_valid   <= w_valid_d;
            w_row_idx <= w_row_idx_d;
            busy      <= busy_d;
            init_done <= init_done_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

`ifdef WFS_STALL_STATS_EN
    logic [STALL_W-1:0] stall_q;

    // Saturating backpressure counter, restarted for every accepted job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (accept_c) begin
            stall_q <= '0;
        end else if (w_valid && !w_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = STALL_W'(0);
`endif

endmodule

// File: tb/tb_weight_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_weight_fetch_seq
// Bench for weight_fetch_seq: a job-level reference model predicts every
// output each cycle; directed scenarios add literal expectations, followed by
// a randomized traffic phase.
// ---------------------------------------------------------------------------
module tb_weight_fetch_seq;

    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned ROW_STRIDE  = 10;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned INIT_CYCLES = 100;
    localparam int unsigned READ_LAT    = 1;
`ifdef WFS_STALL_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              start     = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  row_count = '0;
    logic              abort     = 1'b0;
    logic              w_ready   = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_in;
    logic              ram_we;
    logic              w_valid;
    logic [CNT_W-1:0]  w_row_idx;
    logic              busy;
    logic              init_done;
    logic              done;
    logic              err;
    logic [15:0]       stall_cnt;

    weight_fetch_seq #(
        .ADDR_W      (ADDR_W),
        .ROW_STRIDE  (ROW_STRIDE),
        .CNT_W       (CNT_W),
        .INIT_CYCLES (INIT_CYCLES),
        .READ_LAT    (READ_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .row_count (row_count),
        .abort     (abort),
        .w_ready   (w_ready),
        .ram_addr  (ram_addr),
        .ram_in    (ram_in),
        .ram_we    (ram_we),
        .w_valid   (w_valid),
        .w_row_idx (w_row_idx),
        .busy      (busy),
        .init_done (init_done),
        .done      (done),
        .err       (err),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (job level) ----------------
    // m_t counts clocks since the current row started (job accept or previous
    // handshake): the address is issued at m_t==1 and the row is valid from
    // m_t==2+READ_LAT on.
    int m_init_left = INIT_CYCLES;
    bit m_active    = 1'b0;
    int m_base      = 0;
    int m_count     = 0;
    int m_idx       = 0;
    int m_t         = 0;
    int m_addr      = 0;
    int m_stall     = 0;
    bit m_done      = 1'b0;
    bit m_err       = 1'b0;
    bit m_chk_en    = 1'b0;

    function automatic bit m_valid();
        return m_active && (m_t >= int'(2 + READ_LAT));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init_left = INIT_CYCLES;
            m_active    = 1'b0;
            m_idx       = 0;
            m_t         = 0;
            m_addr      = 0;
            m_stall     = 0;
            m_done      = 1'b0;
            m_err       = 1'b0;
        end else begin
            bit cur_valid;
            cur_valid = m_valid();
            m_done    = 1'b0;
            m_err     = 1'b0;
            if (cur_valid && !w_ready && m_stall < 65535) m_stall++;
            if (m_init_left > 0) begin
                m_init_left--;
            end else if (!m_active) begin
                if (start) begin
                    if (row_count == 0) begin
                        m_done = 1'b1;
                    end else if (int'(base_addr) + int'(row_count) * int'(ROW_STRIDE) > (1 << ADDR_W)) begin
                        m_err = 1'b1;
                    end else begin
                        m_active = 1'b1;
                        m_base   = int'(base_addr);
                        m_count  = int'(row_count);
                        m_idx    = 0;
                        m_t      = 0;
                        m_stall  = 0;
                    end
                end
            end else if (abort) begin
                m_active = 1'b0;
            end else if (cur_valid && w_ready) begin
                if (m_idx == m_count - 1) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_idx++;
                    m_t = 0;
                end
            end else begin
                m_t++;
                if (m_t == 1) m_addr = m_base + m_idx * int'(ROW_STRIDE);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_chk_en) begin
            check("ram_addr",  ram_addr,  m_addr);
            check("ram_in",    ram_in,    longint'(m_init_left != 0));
            check("ram_we",    ram_we,    0);
            check("w_valid",   w_valid,   longint'(m_valid()));
            check("w_row_idx", w_row_idx, m_idx);
            check("busy",      busy,      longint'(m_active));
            check("init_done", init_done, longint'(m_init_left == 0));
            check("done",      done,      longint'(m_done));
            check("err",       err,       longint'(m_err));
            check("stall_cnt", stall_cnt, STATS_EN ? m_stall : 0);
            check("done_err_excl", longint'(done && err), 0);
        end
    end

    // ---------------- transaction monitor ----------------
    int n_done  = 0;
    int n_err   = 0;
    int n_valid = 0;
    int hs_addr[$];
    int hs_idx[$];

    always @(negedge clk) begin
        if (w_valid && w_ready) begin
            hs_addr.push_back(int'(ram_addr));
            hs_idx.push_back(int'(w_row_idx));
        end
        if (done)    n_done++;
        if (err)     n_err++;
        if (w_valid) n_valid++;
    end

    task automatic clear_mon();
        n_done  = 0;
        n_err   = 0;
        n_valid = 0;
        hs_addr.delete();
        hs_idx.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int c);
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        row_count = CNT_W'(c);
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 400);
        check({name, "_idle_timeout"}, busy, 0);
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!w_valid && n < 50);
        check({name, "_valid_timeout"}, w_valid, 1);
    endtask

    // Release reset and measure the initialise window; a start during INIT is ignored.
    task automatic release_and_init(input string name);
        int n;
        n     = 0;
        rst_n = 1'b1;
        while (!init_done && n < 300) begin
            tick();
            n++;
            start     = (n == 50);
            base_addr = '0;
            row_count = CNT_W'(1);
            if (n == 60) check({name, "_busy_in_init"}, busy, 0);
            if (n == 99) check({name, "_ram_in_99"}, ram_in, 1);
        end
        start = 1'b0;
        check({name, "_init_len"}, n, 100);
        check({name, "_ram_in_after"}, ram_in, 0);
        check({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int exp_a[5];
        int n;

        #1 rst_n = 1'b0;
        m_chk_en = 1'b1;
        repeat (3) tick();
        check("rst_ram_in", ram_in, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_init_done", init_done, 0);
        check("rst_stall", stall_cnt, 0);

        release_and_init("init1");

        // Five rows from address 0 with the consumer always ready.
        clear_mon();
        w_ready = 1'b1;
        do_start(0, 5);
        wait_idle("t2");
        exp_a = '{0, 10, 20, 30, 40};
        check("t2_rows", hs_addr.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_addr", (i < hs_addr.size()) ? hs_addr[i] : -1, exp_a[i]);
            check("t2_idx",  (i < hs_idx.size())  ? hs_idx[i]  : -1, i);
        end
        check("t2_done", n_done, 1);
        check("t2_valid_cycles", n_valid, 5);

        // Backpressure for 7 clocks on row 1.
        clear_mon();
        w_ready = 1'b1;
        do_start(20, 3);
        wait_valid("t3_row0");
        tick();
        w_ready = 1'b0;
        wait_valid("t3_row1");
        check("t3_row1_idx", w_row_idx, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t3_hold_addr", ram_addr, 30);
            check("t3_hold_valid", w_valid, 1);
            check("t3_hold_idx", w_row_idx, 1);
        end
        w_ready = 1'b1;
        wait_idle("t3");
        check("t3_stall", stall_cnt, STATS_EN ? 7 : 0);
        check("t3_rows", hs_addr.size(), 3);
        check("t3_addr1", (hs_addr.size() > 1) ? hs_addr[1] : -1, 30);
        check("t3_done", n_done, 1);

        // Range rejection, empty job, and a job ending exactly at the top.
        clear_mon();
        do_start(120, 2);
        wait_idle("t4a");
        check("t4a_err", n_err, 1);
        check("t4a_done", n_done, 0);
        check("t4a_valid", n_valid, 0);
        clear_mon();
        do_start(0, 0);
        wait_idle("t4b");
        check("t4b_done", n_done, 1);
        check("t4b_err", n_err, 0);
        check("t4b_valid", n_valid, 0);
        clear_mon();
        do_start(78, 5);
        wait_idle("t4c");
        check("t4c_rows", hs_addr.size(), 5);
        check("t4c_last", (hs_addr.size() == 5) ? hs_addr[4] : -1, 118);
        check("t4c_err", n_err, 0);
        clear_mon();
        do_start(79, 5);
        wait_idle("t4d");
        check("t4d_err", n_err, 1);

        // Abort in WAIT of row 2, then a fresh job.
        clear_mon();
        w_ready = 1'b1;
        do_start(0, 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(w_valid && w_row_idx == 1) && n < 50);
        check("t5_row1_seen", w_row_idx, 1);
        @(posedge clk);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy_after_abort", busy, 0);
        wait_idle("t5");
        check("t5_rows", hs_addr.size(), 2);
        check("t5_done", n_done, 0);
        clear_mon();
        do_start(10, 2);
        wait_idle("t5b");
        check("t5b_rows", hs_addr.size(), 2);
        check("t5b_addr0", (hs_addr.size() > 0) ? hs_addr[0] : -1, 10);
        check("t5b_addr1", (hs_addr.size() > 1) ? hs_addr[1] : -1, 20);
        check("t5b_done", n_done, 1);

        // Reset while a row is presented.
        clear_mon();
        w_ready = 1'b0;
        do_start(0, 3);
        wait_valid("t6");
        #1 rst_n = 1'b0;
        #1;
        check("t6_ram_in", ram_in, 1);
        check("t6_valid", w_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_addr", ram_addr, 0);
        check("t6_init_done", init_done, 0);
        check("t6_idx", w_row_idx, 0);
        check("t6_stall", stall_cnt, 0);
        tick();
        tick();
        release_and_init("init2");

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            w_ready   = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 5) == 0);
            base_addr = ADDR_W'($urandom_range(0, 127));
            row_count = CNT_W'($urandom_range(0, 15));
            abort     = ($urandom_range(0, 60) == 0);
            tick();
        end
        start   = 1'b0;
        abort   = 1'b0;
        w_ready = 1'b1;
        wait_idle("rand");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
